// File: rtl/pp_axis2mat_pkg.sv
// pp_axis2mat_pkg: shared widths and FSM encoding for the AXI-to-Mat pixel unpacker.
package pp_axis2mat_pkg;
    localparam int PIXEL_W = 24;
    localparam int WORD_W  = 64;
    localparam int DIM_W   = 16;
    localparam int BUF_W   = 128;
    localparam int FILL_W  = 8;
    typedef enum logic [2:0] {IDLE, MUL, CNT, RUN, DONE} fsm_t;
endpackage

// File: rtl/pp_axis2mat_bitbuf.sv
// pp_axis2mat_bitbuf: LSB-first bit buffer; words append above the valid bits, pixels leave from the bottom.
module pp_axis2mat_bitbuf
    import pp_axis2mat_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic [WORD_W-1:0]  din,
    output logic [FILL_W-1:0]  fill,
    output logic [PIXEL_W-1:0] pix
);
    logic [BUF_W-1:0]  buf_q, buf_d, kept;
    logic [FILL_W-1:0] fill_q, fill_d, base;
    // Bits above fill are always zero, so appending is a plain OR.
    always_comb begin
        kept   = pop ? buf_q >> PIXEL_W : buf_q;
        base   = pop ? fill_q - FILL_W'(PIXEL_W) : fill_q;
        buf_d  = clr ? '0 : push ? kept | (BUF_W'(din) << base) : kept;
        fill_d = clr ? '0 : push ? base + FILL_W'(WORD_W) : base;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end
    assign fill = fill_q;
    assign pix  = buf_q[PIXEL_W-1:0];
endmodule

// File: rtl/pp_axis_to_mat_unpack.sv
// pp_axis_to_mat_unpack: unpacks 64-bit FIFO words into one 24-bit pixel per cycle (ap_ctrl_chain).
// Define PP_AXIS2MAT_STALL_CNT_EN to add the stall_cycles counter port.
module pp_axis_to_mat_unpack
    import pp_axis2mat_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    output logic               ap_done,
    input  logic               ap_continue,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic [DIM_W-1:0]   rows,
    input  logic [DIM_W-1:0]   cols,
    input  logic [WORD_W-1:0]  ldata_dout,
    input  logic               ldata_empty_n,
    output logic               ldata_read,
    output logic [PIXEL_W-1:0] img_data_din,
    input  logic               img_data_full_n,
    output logic               img_data_write
`ifdef PP_AXIS2MAT_STALL_CNT_EN
   ,output logic [31:0]        stall_cycles
`endif
);
    fsm_t              state_q, state_d;
    logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic [31:0]       pix_left_q, pix_left_d, words_left_q, words_left_d;
    logic              done_reg_q, done_reg_d;
    logic              start_ok, push, pop;
    logic [FILL_W-1:0] fill;
    always_comb begin
        start_ok     = state_q == IDLE && ap_start && !done_reg_q;
        push         = state_q == RUN && words_left_q != 0 && ldata_empty_n && fill <= FILL_W'(WORD_W);
        pop          = state_q == RUN && pix_left_q != 0 && fill >= FILL_W'(PIXEL_W) && img_data_full_n;
        state_d      = state_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        pix_left_d   = pop ? pix_left_q - 32'd1 : pix_left_q;
        words_left_d = push ? words_left_q - 32'd1 : words_left_q;
        done_reg_d   = state_q == DONE ? 1'b1 : ap_continue ? 1'b0 : done_reg_q;
        case (state_q)
            IDLE: if (start_ok) begin
                rows_d  = rows;
                cols_d  = cols;
                state_d = MUL;
            end
            MUL: begin
                pix_left_d = 32'(rows_q) * 32'(cols_q);
                state_d    = CNT;
            end
            CNT: begin
                words_left_d = 32'((35'(pix_left_q) * 35'd3 + 35'd7) >> 3);
                state_d      = pix_left_q == 0 ? DONE : RUN;
            end
            RUN:     state_d = pop && pix_left_q == 32'd1 ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            pix_left_q   <= '0;
            words_left_q <= '0;
            done_reg_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            pix_left_q   <= pix_left_d;
            words_left_q <= words_left_d;
            done_reg_q   <= done_reg_d;
        end
    end
    pp_axis2mat_bitbuf u_bitbuf (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .clr  (start_ok),
        .push (push),
        .pop  (pop),
        .din  (ldata_dout),
        .fill (fill),
        .pix  (img_data_din)
    );
    assign ap_done        = done_reg_q | (state_q == DONE);
    assign ap_ready       = state_q == DONE;
    assign ap_idle        = state_q == IDLE && !ap_start && !ap_rst;
    assign ldata_read     = push;
    assign img_data_write = pop;
`ifdef PP_AXIS2MAT_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_hit;
    always_comb begin
        stall_hit = state_q == RUN && ((fill < FILL_W'(PIXEL_W) && !pop) || (fill >= FILL_W'(PIXEL_W) && !img_data_full_n));
        stall_d   = start_ok ? '0 : stall_hit && stall_q != '1 ? stall_q + 32'd1 : stall_q;
    end
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) stall_q <= '0;
        else        stall_q <= stall_d;
    end
    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pp_axis_to_mat_unpack.sv
// tb_pp_axis_to_mat_unpack: randomized frames checked against a bit-stream model of LSB-first pixel packing.
module tb_pp_axis_to_mat_unpack;
    logic        ap_clk = 0, ap_rst = 1, ap_start = 0, ap_continue = 1;
    logic        ap_done, ap_idle, ap_ready;
    logic [15:0] rows = 0, cols = 0;
    logic [63:0] ldata_dout = 0;
    logic        ldata_empty_n = 0, ldata_read;
    logic [23:0] img_data_din;
    logic        img_data_full_n = 1, img_data_write;
`ifdef PP_AXIS2MAT_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif
    always #5 ap_clk = ~ap_clk;
    pp_axis_to_mat_unpack dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_continue     (ap_continue),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .rows            (rows),
        .cols            (cols),
        .ldata_dout      (ldata_dout),
        .ldata_empty_n   (ldata_empty_n),
        .ldata_read      (ldata_read),
        .img_data_din    (img_data_din),
        .img_data_full_n (img_data_full_n),
        .img_data_write  (img_data_write)
`ifdef PP_AXIS2MAT_STALL_CNT_EN
       ,.stall_cycles    (stall_cycles)
`endif
    );
    int          checks = 0, fails = 0;
    logic [63:0] fifo_q[$], wq[$];
    logic [23:0] want_px[$], got[$];
    int          reads, writes, viol, cyc = 0, start_cyc, first_rd, last_wr, done_cyc, mfill;
    bit          stall;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, want);
        end
    endtask

    // One cycle: drive at the falling edge, observe 1ns later, model the FIFOs.
    task automatic step(input bit st, input bit co);
        int f0;
        @(negedge ap_clk);
        ap_start        = st;
        ap_continue     = co;
        ldata_empty_n   = fifo_q.size() > 0 && (!stall || $urandom_range(1, 0) == 1);
        ldata_dout      = fifo_q.size() > 0 ? fifo_q[0] : {$urandom, $urandom};
        img_data_full_n = !stall || $urandom_range(1, 0) == 1;
        #1;
        cyc++;
        f0 = mfill;
        if (ldata_read) begin
            if (!ldata_empty_n || f0 > 64) viol++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (first_rd < 0) first_rd = cyc;
            reads++;
            mfill += 64;
        end
        if (img_data_write) begin
            if (!img_data_full_n || f0 < 24) viol++;
            got.push_back(img_data_din);
            writes++;
            last_wr = cyc;
            mfill -= 24;
        end
        if (ap_done && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic load(input int r, input int c, input bit stl);
        int n, nw, b;
        logic [63:0] w;
        logic [23:0] px;
        n  = r * c;
        nw = (n * 3 + 7) / 8;
        fifo_q.delete(); wq.delete(); want_px.delete(); got.delete();
        for (int i = 0; i < nw; i++) wq.push_back({$urandom, $urandom});
        foreach (wq[i]) fifo_q.push_back(wq[i]);
        fifo_q.push_back({$urandom, $urandom});
        fifo_q.push_back({$urandom, $urandom});
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 24; i++) begin
                b     = 24 * k + i;
                w     = wq[b / 64];
                px[i] = w[b % 64];
            end
            want_px.push_back(px);
        end
        rows = 16'(r); cols = 16'(c); stall = stl;
        reads = 0; writes = 0; viol = 0; mfill = 0; first_rd = -1; last_wr = -1; done_cyc = -1;
    endtask

    task automatic finish_frame(input bit co);
        int n, nw;
        n  = want_px.size();
        nw = wq.size();
        for (int i = 0; i < 3000 && done_cyc < 0; i++) step(0, co);
        chk("timeout", done_cyc >= 0, 1);
        chk("reads", reads, nw);
        chk("writes", writes, n);
        chk("handshake_viol", viol, 0);
        for (int i = 0; i < n; i++) chk("pixel", got.size() > i ? got[i] : 'x, want_px[i]);
        if (n > 0) chk("done_lat", done_cyc - last_wr, 1);
        else       chk("done_win", done_cyc - start_cyc <= 4, 1);
        if (!stall && n > 0) chk("first_rd", first_rd - start_cyc, 3);
        if (co) begin
            step(0, 1);
            step(0, 1);
        end
    endtask

    task automatic run(input int r, input int c, input bit stl, input bit co);
        load(r, c, stl);
        step(1, co);
        start_cyc = cyc;
        finish_frame(co);
    endtask

    initial begin
        logic [63:0] w0, w1;
        int dl;
        repeat (3) @(negedge ap_clk);
        #1;
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_idle", ap_idle, 0);
        chk("rst_read", ldata_read, 0);
        chk("rst_write", img_data_write, 0);
        chk("rst_din", img_data_din, 0);
        @(negedge ap_clk);
        ap_rst = 0;
        #1;
        chk("idle_after_rst", ap_idle, 1);
        run(1, 8, 0, 1);
        run(1, 3, 0, 1);
        w0 = wq[0];
        w1 = wq[1];
        chk("px2_split", got.size() > 2 ? got[2] : 'x, {w1[7:0], w0[63:48]});
        run(4, 16, 1, 1);
        run(0, 100, 0, 1);
        load(2, 8, 0);
        step(1, 1);
        start_cyc = cyc;
        for (int i = 0; i < 200 && writes < 5; i++) step(0, 1);
        #2 ap_rst = 1;
        #1;
        chk("midrst_read", ldata_read, 0);
        chk("midrst_write", img_data_write, 0);
        chk("midrst_done", ap_done, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst = 0;
        reads = 0;
        writes = 0;
        repeat (6) step(0, 1);
        chk("post_rst_reads", reads, 0);
        chk("post_rst_writes", writes, 0);
        run(1, 8, 0, 1);
        run(1, 8, 0, 0);
        load(1, 8, 0);
        dl = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0);
            if (!ap_done) dl++;
        end
        chk("held_done_low", dl, 0);
        chk("held_reads", reads, 0);
        step(1, 1);
        chk("cont_cycle_reads", reads, 0);
        done_cyc = -1;
        step(1, 1);
        start_cyc = cyc;
        finish_frame(1);
        for (int f = 0; f < 4; f++) run($urandom_range(3, 1), $urandom_range(20, 1), 1'($urandom_range(1, 0)), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
